vga_capture: RTL and testbench
==============================

# vga_capture

Receive-side VGA timing decoder. It takes active-low hsync/vsync and 12-bit RGB in the pixel-clock domain and recovers per-pixel coordinates, a pixel-valid strobe and frame/line markers. It qualifies the incoming timing against a fixed 640x480 mode (800x521 totals) and only asserts pixel-valid while locked. It sits at the sink end of a VGA link, e.g. loopback from the display timing generator into a frame-buffer writer or checker.

## Interface
- H_BP, 48: pixel clocks from the first high hsync sample to the first active pixel
- H_ACTIVE, 640: active pixels per line
- H_TOTAL, 800: pixel clocks per line
- V_BP, 29: lines from the first line after the vsync rise to the first active line
- V_ACTIVE, 480: active lines per frame
- V_TOTAL, 521: lines per frame
- vga_clk_i  in  1  pixel clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- hsync_i  in  1  horizontal sync, low during pulse
- vsync_i  in  1  vertical sync, low during pulse
- rgb_i  in  12  {R,G,B} 4 bits each
- pix_valid_o  out  1  active pixel on rgb_o/x_o/y_o
- x_o  out  10  column 0..H_ACTIVE-1, 0 when not valid
- y_o  out  10  row 0..V_ACTIVE-1, 0 when not valid
- rgb_o  out  12  captured pixel, 0 when not valid
- frame_start_o  out  1  pulse with pixel (0,0)
- line_end_o  out  1  pulse with pixel x=H_ACTIVE-1
- locked_o  out  1  timing qualified
- lock_lost_o  out  1  one-cycle pulse on LOCKED -> SEARCH

## Operation
- Stage 1 registers hsync_i, vsync_i and rgb_i into hs_q, vs_q and rgb_q. It also keeps hs_d and vs_d, which are the previous values of hs_q and vs_q.
- h_rise = hs_q & ~hs_d. v_rise = vs_q & ~vs_d.
- Sample position p (11 bits):
  - 0 on h_rise.
  - Otherwise hpos+1, saturating at 2047.
  - hpos <= p.
- Line index l (10 bits):
  - On h_rise with v_pend=1: l=0, and v_pend is cleared.
  - On h_rise otherwise: l=vline+1, saturating at 1023.
  - Otherwise: l=vline.
  - vline <= l. v_rise sets v_pend.
- h_seen is set on any h_rise and cleared by a timeout or reset.
- h_err: h_rise & h_seen & (hpos != H_TOTAL-1).
- v_err: v_rise & (vline != V_TOTAL-1).
- timeout: hpos reaches 2*H_TOTAL. When it fires, h_seen is cleared and the state goes to SEARCH.
- State machine (2-bit):
  - SEARCH:
    - v_rise -> MEASURE.
  - MEASURE:
    - h_err -> SEARCH.
    - v_rise with no h_err since entry and no v_err -> LOCKED.
    - v_rise otherwise -> MEASURE, restarting the check.
  - LOCKED:
    - h_err, v_err or timeout -> SEARCH, with lock_lost_o=1 for one cycle.
- locked_o = (state==LOCKED), taken from the registered state.
- Output register, computed from the stage-1 sample and p/l:
  - pix_valid_o = locked & (H_BP <= p < H_BP+H_ACTIVE) & (V_BP <= l < V_BP+V_ACTIVE).
  - x_o = p-H_BP; y_o = l-V_BP; rgb_o = rgb_q. All three are zeroed when pix_valid_o=0.
  - frame_start_o = valid & x==0 & y==0.
  - line_end_o = valid & x==H_ACTIVE-1.
- Simultaneous h_rise and v_rise: v_pend is set, and the h_rise still increments l. The frame restart takes effect at the next h_rise.
- Reset (any time, asynchronous):
  - All outputs go to 0.
  - State goes to SEARCH.
  - hs_q/hs_d/vs_q/vs_d go to 1 (idle), so no false edge is detected after reset.
  - hpos, vline and h_seen go to 0; v_pend goes to 0.

## Timing
- Input sampled at edge N -> stage 1 at N -> outputs/state/counters at edge N+1. Fixed latency of 2 edges from pins to outputs.
- locked_o rises at the edge after the stage-1 v_rise that ends the first clean measured frame.
  - From reset on a clean stream, this is the second vsync rise after reset (about 1 frame + 2 cycles).
  - pix_valid_o first asserts in the following frame.
- Reference source timing:
  - hsync low for 96 clocks per 800.
  - First active pixel is 48 clocks after hsync goes high.
  - vsync low for 2 lines; active lines are 29..508 counted from the line where vsync goes high.
  - With this source, pix_valid_o covers exactly 640x480 per frame.
- lock_lost_o and locked_o falling occur on the same edge. pix_valid_o is 0 on that edge.

## Test plan
- Reset: hold rst_i high mid-stream -> all outputs 0 immediately, state SEARCH. Release -> no pix_valid_o before 2 vsync rises.
- Lock from reset: clean 800x521 stream (hsync low clocks 0-95, vsync low lines 0-1) -> locked_o=1 two cycles after the second vsync rise. Next frame gives exactly one frame_start_o, 480 line_end_o and 307200 pix_valid_o cycles.
- Data/coordinate check: source drives rgb={x[3:0],y[3:0],4'hA} at active position (x,y) -> every valid output matches x_o/y_o. Also check x_o 0..639, y_o 0..479, and 2-cycle latency.
- Line glitch: while locked, one line of 799 clocks -> lock_lost_o pulse at the next hsync rise, locked_o=0. Relock after one further clean frame.
- Frame glitch: a frame with 520 lines -> v_err at the vsync rise -> lock_lost_o, SEARCH.
- Sync loss: hold hsync_i high for 2000 clocks while locked -> timeout 1600 clocks after the last rise -> lock_lost_o. No valid pixels until relock.

Source files
------------

// File: rtl/vga_capture.sv
// Purpose : VGA sink timing decoder; recovers x/y, pixel-valid and frame/line markers once 640x480 timing is qualified.
// Latency : 2 vga_clk_i edges from pins to outputs (input register, then output/state register).
// Backpressure: none; free-running pixel stream, every clock carries one sample.
module vga_capture #(
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_BP     = 29,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 521
) (
    input  logic        vga_clk_i,
    input  logic        rst_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [11:0] rgb_i,
    output logic        pix_valid_o,
    output logic [9:0]  x_o,
    output logic [9:0]  y_o,
    output logic [11:0] rgb_o,
    output logic        frame_start_o,
    output logic        line_end_o,
    output logic        locked_o,
    output logic        lock_lost_o
);

    // Sized copies of the geometry so every compare is width-matched.
    localparam logic [10:0] HBP   = 11'(H_BP);
    localparam logic [10:0] HEND  = 11'(H_BP + H_ACTIVE);
    localparam logic [10:0] HLAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] TMO   = 11'(2 * H_TOTAL);
    localparam logic [9:0]  VBP   = 10'(V_BP);
    localparam logic [9:0]  VEND  = 10'(V_BP + V_ACTIVE);
    localparam logic [9:0]  VLAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  XLAST = 10'(H_ACTIVE - 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t      state;
    logic        hs_q, hs_d, vs_q, vs_d;
    logic [11:0] rgb_q;
    logic [10:0] hpos;
    logic [9:0]  vline;
    logic        v_pend;
    logic        h_seen;

    logic        h_rise, v_rise;
    logic [10:0] p;
    logic [9:0]  l;
    logic        h_err, v_err, timeout;
    logic        lose, meas_fail, meas_ok, lock_n;
    logic [9:0]  x_n, y_n;
    logic        pv_n;

    // Input register plus one-cycle history of the syncs; idle-high after reset so no false edge.
    always_ff @(posedge vga_clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_q  <= 1'b1;
            hs_d  <= 1'b1;
            vs_q  <= 1'b1;
            vs_d  <= 1'b1;
            rgb_q <= '0;
        end else begin
            hs_q  <= hsync_i;
            hs_d  <= hs_q;
            vs_q  <= vsync_i;
            vs_d  <= vs_q;
            rgb_q <= rgb_i;
        end
    end

    assign h_rise = hs_q & ~hs_d;
    assign v_rise = vs_q & ~vs_d;

    // Position of the current stage-1 sample: column from hsync rise, line from the line after vsync rise.
    always_comb begin
        p = (hpos == 11'h7FF) ? hpos : hpos + 11'd1;
        if (h_rise) p = '0;
        l = vline;
        if (h_rise) begin
            if (v_pend)              l = '0;
            else if (vline != 10'h3FF) l = vline + 10'd1;
        end
    end

    assign h_err     = h_rise & h_seen & (hpos != HLAST);
    assign v_err     = v_rise & (vline != VLAST);
    assign timeout   = (p == TMO);
    assign lose      = h_err | v_err | timeout;
    assign meas_fail = h_err | timeout;
    assign meas_ok   = v_rise & ~v_err & ~meas_fail;
    // Lock status the state register will hold after this edge; pixel qualification follows it.
    assign lock_n    = (state == LOCKED) ? ~lose : ((state == MEASURE) & meas_ok);

    // Line/frame counters, pending frame restart and hsync-seen tracking.
    always_ff @(posedge vga_clk_i or posedge rst_i) begin
        if (rst_i) begin
            hpos   <= '0;
            vline  <= '0;
            v_pend <= 1'b0;
            h_seen <= 1'b0;
        end else begin
            hpos  <= p;
            vline <= l;
            if (v_rise)
                v_pend <= 1'b1;
            else if (h_rise)
                v_pend <= 1'b0;
            if (timeout)
                h_seen <= 1'b0;
            else if (h_rise)
                h_seen <= 1'b1;
        end
    end

    // Lock qualifier: one clean measured frame takes SEARCH -> LOCKED; any timing error drops lock.
    always_ff @(posedge vga_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= SEARCH;
            locked_o    <= 1'b0;
            lock_lost_o <= 1'b0;
        end else begin
            lock_lost_o <= 1'b0;
            case (state)
                SEARCH: begin
                    if (v_rise && !timeout)
                        state <= MEASURE;
                end
                MEASURE: begin
                    if (meas_fail)
                        state <= SEARCH;
                    else if (meas_ok)
                        state <= LOCKED;
                end
                LOCKED: begin
                    if (lose) begin
                        state       <= SEARCH;
                        lock_lost_o <= 1'b1;
                    end
                end
                default: state <= SEARCH;
            endcase
            locked_o <= lock_n;
        end
    end

    assign x_n  = 10'(p - HBP);
    assign y_n  = l - VBP;
    assign pv_n = lock_n & (p >= HBP) & (p < HEND) & (l >= VBP) & (l < VEND);

    // Pixel output register; coordinates and data are forced to zero outside valid pixels.
    always_ff @(posedge vga_clk_i or posedge rst_i) begin
        if (rst_i) begin
            pix_valid_o   <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
            rgb_o         <= '0;
            frame_start_o <= 1'b0;
            line_end_o    <= 1'b0;
        end else begin
            pix_valid_o   <= pv_n;
            x_o           <= pv_n ? x_n : '0;
            y_o           <= pv_n ? y_n : '0;
            rgb_o         <= pv_n ? rgb_q : '0;
            frame_start_o <= pv_n & (x_n == '0) & (y_n == '0);
            line_end_o    <= pv_n & (x_n == XLAST);
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a scaled-down mode (40x12 totals) so each frame is 480 clocks.
// Source: hsync low hc 0..3, vsync low vc 0..1, active hc 10..29 / vc 5..10, rgb={x,y,A}.
module tb_vga_capture;

    localparam int HBP = 6, HACT = 20, HTOT = 40;
    localparam int VBP = 3, VACT = 6, VTOT = 12;
    localparam int HSW = 4, VSW = 2;
    localparam int X0 = HSW + HBP;   // first active source column
    localparam int Y0 = VSW + VBP;   // first active source line

    logic        vga_clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        hsync_i = 1'b1;
    logic        vsync_i = 1'b1;
    logic [11:0] rgb_i = '0;
    logic        pix_valid_o;
    logic [9:0]  x_o, y_o;
    logic [11:0] rgb_o;
    logic        frame_start_o, line_end_o, locked_o, lock_lost_o;

    vga_capture #(
        .H_BP(HBP), .H_ACTIVE(HACT), .H_TOTAL(HTOT),
        .V_BP(VBP), .V_ACTIVE(VACT), .V_TOTAL(VTOT)
    ) dut (
        .vga_clk_i    (vga_clk_i),
        .rst_i        (rst_i),
        .hsync_i      (hsync_i),
        .vsync_i      (vsync_i),
        .rgb_i        (rgb_i),
        .pix_valid_o  (pix_valid_o),
        .x_o          (x_o),
        .y_o          (y_o),
        .rgb_o        (rgb_o),
        .frame_start_o(frame_start_o),
        .line_end_o   (line_end_o),
        .locked_o     (locked_o),
        .lock_lost_o  (lock_lost_o)
    );

    always #5 vga_clk_i = ~vga_clk_i;

    int total = 0;
    int bad   = 0;

    // source position and modifiers
    int hc = 0, vc = 0;
    int h_len = HTOT, v_len = VTOT;
    bit hs_hold = 1'b0;
    // source position whose result is visible on the outputs now
    int h_d = 0, v_d = 0;
    bit chk_geom = 1'b0;

    int cnt_valid, cnt_fs, cnt_le, cnt_lost, pix_bad, x_max, y_max, fs_h, fs_v;

    function automatic logic [11:0] src_rgb(input int h, input int v);
        logic [3:0] xs, ys;
        if (h >= X0 && h < X0 + HACT && v >= Y0 && v < Y0 + VACT) begin
            xs = 4'(h - X0);
            ys = 4'(v - Y0);
            return {xs, ys, 4'hA};
        end
        return 12'h5C3;
    endfunction

    task automatic drive();
        hsync_i = hs_hold ? 1'b1 : (hc >= HSW);
        vsync_i = (vc >= VSW);
        rgb_i   = src_rgb(hc, vc);
    endtask

    task automatic clear_counts();
        cnt_valid = 0; cnt_fs = 0; cnt_le = 0; cnt_lost = 0;
        pix_bad = 0; x_max = 0; y_max = 0; fs_h = -1; fs_v = -1;
    endtask

    // One clock: observe outputs, then advance and drive the source.
    task automatic tick();
        bit ev;
        @(posedge vga_clk_i);
        #1;
        ev = (h_d >= X0 && h_d < X0 + HACT && v_d >= Y0 && v_d < Y0 + VACT);
        if (chk_geom) begin
            if (pix_valid_o !== ev)
                pix_bad++;
            else if (ev && (x_o !== 10'(h_d - X0) || y_o !== 10'(v_d - Y0) || rgb_o !== src_rgb(h_d, v_d)))
                pix_bad++;
            else if (!ev && (x_o !== '0 || y_o !== '0 || rgb_o !== '0))
                pix_bad++;
        end
        if (pix_valid_o === 1'b1) begin
            cnt_valid++;
            if (int'(x_o) > x_max) x_max = int'(x_o);
            if (int'(y_o) > y_max) y_max = int'(y_o);
        end
        if (frame_start_o === 1'b1) begin cnt_fs++; fs_h = h_d; fs_v = v_d; end
        if (line_end_o === 1'b1) cnt_le++;
        if (lock_lost_o === 1'b1) cnt_lost++;
        h_d = hc;
        v_d = vc;
        hc++;
        if (hc >= h_len) begin
            hc = 0;
            vc++;
            if (vc >= v_len) vc = 0;
        end
        drive();
    endtask

    // Advance until the source is about to drive (h,v); bounded.
    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(hc == h && vc == v) && n < 5000) begin
            tick();
            n++;
        end
        total++;
        if (!(hc == h && vc == v)) begin
            bad++;
            $display("FAIL run_to: reached (%0d,%0d) required (%0d,%0d)", hc, vc, h, v);
        end
    endtask

    // From SEARCH: first vsync rise -> MEASURE, second -> LOCKED exactly 2 clocks after it is driven.
    task automatic check_relock(input string nm);
        clear_counts();
        run_to(0, 2);
        tick(); tick();
        total++;
        if (locked_o !== 1'b0) begin bad++; $display("FAIL %s_measure_locked: got %b want 0", nm, locked_o); end
        run_to(0, 2);
        tick();
        total++;
        if (locked_o !== 1'b0) begin bad++; $display("FAIL %s_early_lock: got %b want 0", nm, locked_o); end
        tick();
        total++;
        if (locked_o !== 1'b1) begin bad++; $display("FAIL %s_lock_rise: got %b want 1", nm, locked_o); end
        total++;
        if (cnt_valid !== 0) begin bad++; $display("FAIL %s_valid_before_lock: got %0d want 0", nm, cnt_valid); end
    endtask

    task automatic test_reset();
        #23;
        total++;
        if ({pix_valid_o, x_o, y_o, rgb_o, frame_start_o, line_end_o, lock_lost_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b x=%0d y=%0d rgb=%h fs=%b le=%b ll=%b want all 0",
                     pix_valid_o, x_o, y_o, rgb_o, frame_start_o, line_end_o, lock_lost_o);
        end
        total++;
        if (locked_o !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked_o); end
        @(posedge vga_clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_lock();
        check_relock("por");
    endtask

    // Full locked frame: counts, geometry, data and coordinate ranges.
    task automatic test_frame();
        clear_counts();
        chk_geom = 1'b1;
        run_to(0, 0);
        chk_geom = 1'b0;
        total++;
        if (cnt_valid !== HACT * VACT) begin bad++; $display("FAIL frame_valid_count: got %0d want %0d", cnt_valid, HACT * VACT); end
        total++;
        if (cnt_fs !== 1) begin bad++; $display("FAIL frame_start_count: got %0d want 1", cnt_fs); end
        total++;
        if (cnt_le !== VACT) begin bad++; $display("FAIL line_end_count: got %0d want %0d", cnt_le, VACT); end
        total++;
        if (pix_bad !== 0) begin bad++; $display("FAIL pixel_data: got %0d bad cycles want 0", pix_bad); end
        total++;
        if (fs_h !== X0 || fs_v !== Y0) begin bad++; $display("FAIL frame_start_pos: got (%0d,%0d) want (%0d,%0d)", fs_h, fs_v, X0, Y0); end
        total++;
        if (x_max !== HACT - 1 || y_max !== VACT - 1) begin bad++; $display("FAIL coord_max: got (%0d,%0d) want (%0d,%0d)", x_max, y_max, HACT - 1, VACT - 1); end
        total++;
        if (cnt_lost !== 0) begin bad++; $display("FAIL frame_lock_lost: got %0d want 0", cnt_lost); end
    endtask

    // Explicit 2-clock latency and first/last pixel of a frame.
    task automatic test_data();
        run_to(X0, Y0);
        tick();
        total++;
        if (pix_valid_o !== 1'b0) begin bad++; $display("FAIL pre_first_pixel: got %b want 0", pix_valid_o); end
        tick();
        total++;
        if ({pix_valid_o, frame_start_o, x_o, y_o, rgb_o} !== {1'b1, 1'b1, 10'd0, 10'd0, 12'h00A}) begin
            bad++;
            $display("FAIL first_pixel: got v=%b fs=%b x=%0d y=%0d rgb=%h want 1 1 0 0 00a", pix_valid_o, frame_start_o, x_o, y_o, rgb_o);
        end
        run_to(X0 + HACT - 1, Y0 + VACT - 1);
        tick(); tick();
        total++;
        if ({pix_valid_o, line_end_o, x_o, y_o, rgb_o} !== {1'b1, 1'b1, 10'd19, 10'd5, 12'h35A}) begin
            bad++;
            $display("FAIL last_pixel: got v=%b le=%b x=%0d y=%0d rgb=%h want 1 1 19 5 35a", pix_valid_o, line_end_o, x_o, y_o, rgb_o);
        end
        tick();
        total++;
        if ({pix_valid_o, line_end_o, x_o, y_o, rgb_o} !== '0) begin
            bad++;
            $display("FAIL after_last_pixel: got v=%b le=%b x=%0d y=%0d rgb=%h want all 0", pix_valid_o, line_end_o, x_o, y_o, rgb_o);
        end
    endtask

    task automatic test_reset_midstream();
        run_to(20, 7);
        tick(); tick();
        total++;
        if (pix_valid_o !== 1'b1 || x_o !== 10'd10 || y_o !== 10'd2) begin
            bad++;
            $display("FAIL pre_reset_pixel: got v=%b x=%0d y=%0d want 1 10 2", pix_valid_o, x_o, y_o);
        end
        rst_i = 1'b1;
        #2;
        total++;
        if ({pix_valid_o, x_o, y_o, rgb_o, frame_start_o, line_end_o, locked_o, lock_lost_o} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got v=%b x=%0d y=%0d rgb=%h lk=%b want all 0", pix_valid_o, x_o, y_o, rgb_o, locked_o);
        end
        tick(); tick(); tick();
        rst_i = 1'b0;
        check_relock("rst");
    endtask

    task automatic test_line_glitch();
        run_to(0, 6);
        h_len = HTOT - 1;
        run_to(0, 7);
        h_len = HTOT;
        clear_counts();
        run_to(HSW, 7);
        tick();
        total++;
        if (locked_o !== 1'b1 || lock_lost_o !== 1'b0) begin bad++; $display("FAIL line_pre_err: got lk=%b ll=%b want 1 0", locked_o, lock_lost_o); end
        tick();
        total++;
        if ({lock_lost_o, locked_o, pix_valid_o} !== 3'b100) begin
            bad++;
            $display("FAIL line_lock_lost: got ll=%b lk=%b v=%b want 1 0 0", lock_lost_o, locked_o, pix_valid_o);
        end
        tick();
        total++;
        if (lock_lost_o !== 1'b0 || cnt_lost !== 1) begin bad++; $display("FAIL line_lost_pulse: got ll=%b count=%0d want 0 1", lock_lost_o, cnt_lost); end
        check_relock("line");
    endtask

    task automatic test_frame_glitch();
        run_to(0, 0);
        v_len = VTOT - 1;
        tick();
        run_to(0, 0);
        v_len = VTOT;
        run_to(0, 2);
        tick();
        total++;
        if (locked_o !== 1'b1) begin bad++; $display("FAIL frame_pre_err: got %b want 1", locked_o); end
        tick();
        total++;
        if ({lock_lost_o, locked_o, pix_valid_o} !== 3'b100) begin
            bad++;
            $display("FAIL frame_lock_lost: got ll=%b lk=%b v=%b want 1 0 0", lock_lost_o, locked_o, pix_valid_o);
        end
        check_relock("frame");
    endtask

    task automatic test_sync_loss();
        run_to(X0, 6);
        hs_hold = 1'b1;
        drive();
        // last hsync rise was at (4,6); timeout lands 2*HTOT clocks later at (4,8)
        run_to(HSW, 8);
        tick();
        total++;
        if (locked_o !== 1'b1 || lock_lost_o !== 1'b0) begin bad++; $display("FAIL sync_pre_timeout: got lk=%b ll=%b want 1 0", locked_o, lock_lost_o); end
        tick();
        total++;
        if ({lock_lost_o, locked_o, pix_valid_o} !== 3'b100) begin
            bad++;
            $display("FAIL sync_timeout: got ll=%b lk=%b v=%b want 1 0 0", lock_lost_o, locked_o, pix_valid_o);
        end
        clear_counts();
        run_to(30, 8);
        hs_hold = 1'b0;
        total++;
        if (cnt_valid !== 0) begin bad++; $display("FAIL sync_valid_while_lost: got %0d want 0", cnt_valid); end
        check_relock("sync");
    endtask

    initial begin
        drive();
        test_reset();
        test_lock();
        test_frame();
        test_data();
        test_reset_midstream();
        test_frame();
        test_line_glitch();
        test_frame_glitch();
        test_sync_loss();
        test_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
